// File: rtl/nmea_pkg.sv
// rtl/nmea_pkg.sv - shared ASCII constants, parser state encoding and hex digit decoder
package nmea_pkg;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MATCH,
    ST_CAPTURE,
    ST_CS_HI,
    ST_CS_LO
  } parse_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  function automatic hex_nib_t hex_to_nibble(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b1;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      r.nib = 4'(c - 8'h30);
    else if (c >= 8'h41 && c <= 8'h46) r.nib = 4'(c - 8'h37);
    else if (c >= 8'h61 && c <= 8'h66) r.nib = 4'(c - 8'h57);
    else                               r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/nmea_capture_if.sv
// rtl/nmea_capture_if.sv - byte stream handshake bundle carrying captured frame payload
interface nmea_capture_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nmea_frame_streamer.sv
// rtl/nmea_frame_streamer.sv - ping-pong payload banks, commit bookkeeping and stream readout
module nmea_frame_streamer
  import nmea_pkg::*;
#(
  parameter int N_BITS      = 8,
  parameter int INFO_SIZE   = 32,
  parameter int AUTO_STREAM = 0,
  localparam int LEN_W      = $clog2(INFO_SIZE + 1),
  localparam int ADDR_W     = $clog2(INFO_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [N_BITS-1:0] wr_data,
  input  logic              commit_req,
  input  logic [LEN_W-1:0]  commit_len,
  input  logic              tx_start,
  output logic              busy,
  output logic              frame_valid,
  output logic [LEN_W-1:0]  frame_len,
  nmea_capture_if.master    m
);

  logic [N_BITS-1:0] mem [0:1][0:INFO_SIZE-1];
  logic              rd_bank;
  logic              s_bank;
  logic [LEN_W-1:0]  s_len;
  logic [LEN_W-1:0]  rd_idx;
  logic              do_commit;
  logic              do_start;
  logic              st_bank;
  logic [LEN_W-1:0]  st_len;

  assign busy = m.tvalid;

  // A start coinciding with an accepted commit streams the frame just committed.
  always_comb begin
    do_commit = commit_req && !busy;
    st_bank   = do_commit ? ~rd_bank : rd_bank;
    st_len    = do_commit ? commit_len : frame_len;
    do_start  = !busy && (tx_start || (AUTO_STREAM != 0 && do_commit))
                && (frame_valid || do_commit) && (st_len != '0);
  end

  // Banks hold payload only; they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[~rd_bank][ADDR_W'(wr_addr)] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank     <= 1'b0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      s_bank      <= 1'b0;
      s_len       <= '0;
      rd_idx      <= '0;
      m.tvalid    <= 1'b0;
      m.tdata     <= '0;
      m.tlast     <= 1'b0;
    end else begin
      if (do_commit) begin
        rd_bank     <= ~rd_bank;
        frame_len   <= commit_len;
        frame_valid <= 1'b1;
      end
      if (do_start) begin
        s_bank   <= st_bank;
        s_len    <= st_len;
        rd_idx   <= LEN_W'(1);
        m.tvalid <= 1'b1;
        m.tdata  <= mem[st_bank][0];
        m.tlast  <= (st_len == LEN_W'(1));
      end else if (m.tvalid && m.tready) begin
        if (m.tlast) begin
          m.tvalid <= 1'b0;
          m.tlast  <= 1'b0;
        end else begin
          m.tdata <= mem[s_bank][ADDR_W'(rd_idx)];
          m.tlast <= (rd_idx == s_len - 1'b1);
          rd_idx  <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nmea_capture.sv
// rtl/nmea_capture.sv - NMEA sentence matcher with checksum verification, statistics and frame streaming
module nmea_capture
  import nmea_pkg::*;
#(
  parameter int N_BITS                              = 8,
  parameter int PATTERN_SIZE                        = 6,
  parameter logic [N_BITS*PATTERN_SIZE-1:0] PATTERN = "GPZDA,",
  parameter int INFO_SIZE                           = 32,
  parameter int AUTO_STREAM                         = 0,
  parameter int CNT_W                               = 16,
  localparam int LEN_W                              = $clog2(INFO_SIZE + 1),
  localparam int IDX_W                              = (PATTERN_SIZE > 1) ? $clog2(PATTERN_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] char_in,
  input  logic              char_valid,
  input  logic              tx_start,
  nmea_capture_if.master    m,
  output logic              frame_valid,
  output logic [LEN_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt,
  output logic [CNT_W-1:0]  ovr_cnt
);

  localparam logic [N_BITS-1:0] CH_DOLLAR = N_BITS'(ASCII_DOLLAR);
  localparam logic [N_BITS-1:0] CH_STAR   = N_BITS'(ASCII_STAR);

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  parse_state_t      state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [LEN_W-1:0]  cap_len, cap_len_nxt;
  logic [N_BITS-1:0] xor_acc, xor_nxt;
  logic [3:0]        cs_hi, cs_hi_nxt;
  logic              wr_en, commit_req, bad_evt, ovr_evt;
  logic              strm_busy, good_inc, ovr_inc;
  logic [N_BITS-1:0] pat_byte;
  hex_nib_t          hex;

  // Assertion is immediate; release is retimed through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign hex = hex_to_nibble(8'(char_in));

  always_comb begin
    pat_byte = '0;
    for (int i = 0; i < PATTERN_SIZE; i++)
      if (IDX_W'(i) == idx) pat_byte = PATTERN[N_BITS*(PATTERN_SIZE-1-i) +: N_BITS];
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cap_len_nxt = cap_len;
    xor_nxt     = xor_acc;
    cs_hi_nxt   = cs_hi;
    wr_en       = 1'b0;
    commit_req  = 1'b0;
    bad_evt     = 1'b0;
    ovr_evt     = 1'b0;
    if (char_valid) begin
      if (char_in == CH_DOLLAR) begin
        state_nxt   = ST_MATCH;
        idx_nxt     = '0;
        cap_len_nxt = '0;
        xor_nxt     = '0;
      end else begin
        case (state)
          ST_IDLE: state_nxt = ST_IDLE;
          ST_MATCH: begin
            if (char_in == pat_byte) begin
              xor_nxt = xor_acc ^ char_in;
              if (idx == IDX_W'(PATTERN_SIZE - 1)) state_nxt = ST_CAPTURE;
              else                                 idx_nxt   = idx + 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
          ST_CAPTURE: begin
            if (char_in == CH_STAR) begin
              state_nxt = ST_CS_HI;
            end else if (cap_len == LEN_W'(INFO_SIZE)) begin
              state_nxt = ST_IDLE;
              ovr_evt   = 1'b1;
            end else begin
              wr_en       = 1'b1;
              cap_len_nxt = cap_len + 1'b1;
              xor_nxt     = xor_acc ^ char_in;
            end
          end
          ST_CS_HI: begin
            if (hex.valid) begin
              cs_hi_nxt = hex.nib;
              state_nxt = ST_CS_LO;
            end else begin
              bad_evt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_CS_LO: begin
            state_nxt = ST_IDLE;
            if (hex.valid && ({cs_hi, hex.nib} == 8'(xor_acc))) commit_req = 1'b1;
            else                                               bad_evt    = 1'b1;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // A commit arriving while the other bank is streaming is lost and counted as an overrun.
  assign good_inc = commit_req && !strm_busy;
  assign ovr_inc  = ovr_evt || (commit_req && strm_busy);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cap_len  <= '0;
      xor_acc  <= '0;
      cs_hi    <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      ovr_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cap_len <= cap_len_nxt;
      xor_acc <= xor_nxt;
      cs_hi   <= cs_hi_nxt;
      if (good_inc && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (bad_evt  && bad_cnt  != '1) bad_cnt  <= bad_cnt + 1'b1;
      if (ovr_inc  && ovr_cnt  != '1) ovr_cnt  <= ovr_cnt + 1'b1;
    end
  end

  nmea_frame_streamer #(
    .N_BITS      (N_BITS),
    .INFO_SIZE   (INFO_SIZE),
    .AUTO_STREAM (AUTO_STREAM)
  ) u_streamer (
    .clk         (clk),
    .rst_n       (rst_int_n),
    .wr_en       (wr_en),
    .wr_addr     (cap_len),
    .wr_data     (char_in),
    .commit_req  (commit_req),
    .commit_len  (cap_len),
    .tx_start    (tx_start),
    .busy        (strm_busy),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .m           (m)
  );

endmodule

// File: tb/tb_nmea_capture.sv
// tb/tb_nmea_capture.sv - directed self-checking bench for nmea_capture
module tb_nmea_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] c0, c1;
  logic       v0, v1, tx0, tx1;
  logic       fv0, fv1;
  logic [5:0] fl0;
  logic [3:0] fl1;
  logic [15:0] g0, b0, o0, g1, b1, o1;
  int checks = 0;
  int failures = 0;

  nmea_capture_if #(.N_BITS(8)) ax0 ();
  nmea_capture_if #(.N_BITS(8)) ax1 ();

  nmea_capture dut0 (
    .clk(clk), .rst_n(rst_n), .char_in(c0), .char_valid(v0), .tx_start(tx0), .m(ax0),
    .frame_valid(fv0), .frame_len(fl0), .good_cnt(g0), .bad_cnt(b0), .ovr_cnt(o0)
  );

  nmea_capture #(.INFO_SIZE(8), .AUTO_STREAM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .char_in(c1), .char_valid(v1), .tx_start(tx1), .m(ax1),
    .frame_valid(fv1), .frame_len(fl1), .good_cnt(g1), .bad_cnt(b1), .ovr_cnt(o1)
  );

  logic [7:0] q0d[$], q1d[$];
  bit         q0l[$], q1l[$];
  logic       stalled1 = 1'b0;
  logic [7:0] sd1;
  logic       sl1;
  int         stall_err = 0;

  // Beats seen valid&ready at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (ax0.tvalid && ax0.tready) begin q0d.push_back(ax0.tdata); q0l.push_back(ax0.tlast); end
    if (ax1.tvalid && ax1.tready) begin q1d.push_back(ax1.tdata); q1l.push_back(ax1.tlast); end
    if (stalled1 && (!ax1.tvalid || ax1.tdata !== sd1 || ax1.tlast !== sl1)) stall_err++;
    stalled1 = ax1.tvalid && !ax1.tready;
    sd1 = ax1.tdata;
    sl1 = ax1.tlast;
  end

  function automatic logic [7:0] xsum(input string s);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < s.len(); i++) x = x ^ s[i];
    return x;
  endfunction

  function automatic logic [7:0] hexd(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  task automatic send_char(input int d, input logic [7:0] c);
    if (d == 0) begin c0 = c; v0 = 1'b1; end
    else        begin c1 = c; v1 = 1'b1; end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic send_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) send_char(d, s[i]);
  endtask

  task automatic send_frame(input int d, input string body, input logic [7:0] flip, input bit lower);
    logic [7:0] cs;
    cs = xsum(body) ^ flip;
    send_char(d, 8'h24);
    send_str(d, body);
    send_char(d, 8'h2A);
    send_char(d, hexd(cs[7:4], lower));
    send_char(d, hexd(cs[3:0], lower));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c0 = '0; c1 = '0; v0 = 1'b0; v1 = 1'b0; tx0 = 1'b0; tx1 = 1'b0;
    ax0.tready = 1'b1; ax1.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    checks++; if ({ax0.tvalid, ax0.tlast, ax0.tdata} !== 10'h0) begin failures++; $display("FAIL rst_stream0 got=%0h exp=0", {ax0.tvalid, ax0.tlast, ax0.tdata}); end
    checks++; if ({fv0, fl0} !== 7'h0) begin failures++; $display("FAIL rst_frame0 got=%0h exp=0", {fv0, fl0}); end
    checks++; if ({g0, b0, o0} !== 48'h0) begin failures++; $display("FAIL rst_cnt0 got=%0h exp=0", {g0, b0, o0}); end
    checks++; if ({ax1.tvalid, fv1, fl1, g1, b1, o1} !== 54'h0) begin failures++; $display("FAIL rst_dut1 got=%0h exp=0", {ax1.tvalid, fv1, fl1, g1, b1, o1}); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    tx0 = 1'b1; @(posedge clk); #1; tx0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (q0d.size() !== 0 || ax0.tvalid !== 1'b0) begin failures++; $display("FAIL tx_before_frame beats=%0d tvalid=%0b exp 0/0", q0d.size(), ax0.tvalid); end
  endtask

  task automatic test_bad_checksum();
    q0d.delete(); q0l.delete();
    send_frame(0, "GPZDA,201530.00,04,07,2002,00,00", 8'h01, 1'b0);
    checks++; if (b0 !== 16'd1) begin failures++; $display("FAIL bad_cs_cnt got=%0d exp=1", b0); end
    checks++; if (fv0 !== 1'b0 || g0 !== 16'd0) begin failures++; $display("FAIL bad_cs_nocommit fv=%0b good=%0d exp 0/0", fv0, g0); end
    send_str(0, "$GPZDA,1*G0");
    checks++; if (b0 !== 16'd2) begin failures++; $display("FAIL nonhex_cs got=%0d exp=2", b0); end
    tx0 = 1'b1; @(posedge clk); #1; tx0 = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (q0d.size() !== 0) begin failures++; $display("FAIL bad_cs_tx beats=%0d exp=0", q0d.size()); end
  endtask

  task automatic test_wrong_id();
    send_frame(0, "GPRMC,123", 8'h00, 1'b0);
    checks++; if ({g0, b0, o0} !== {16'd0, 16'd2, 16'd0}) begin failures++; $display("FAIL wrong_id cnts good=%0d bad=%0d ovr=%0d exp 0/2/0", g0, b0, o0); end
    send_str(0, "$GP");
    send_frame(0, "GPZDA,201530.00,04,07,2002,00,00", 8'h00, 1'b0);
    checks++; if (g0 !== 16'd1 || b0 !== 16'd2) begin failures++; $display("FAIL restart_commit good=%0d bad=%0d exp 1/2", g0, b0); end
    checks++; if (fv0 !== 1'b1 || fl0 !== 6'd26) begin failures++; $display("FAIL restart_len fv=%0b len=%0d exp 1/26", fv0, fl0); end
  endtask

  task automatic test_stream();
    string exp_s;
    logic [7:0] e;
    bit done;
    exp_s = "201530.00,04,07,2002,00,00";
    q0d.delete(); q0l.delete();
    tx0 = 1'b1; @(posedge clk); #1; tx0 = 1'b0;
    checks++; if (ax0.tvalid !== 1'b1 || ax0.tdata !== 8'h32) begin failures++; $display("FAIL first_beat tvalid=%0b data=%0h exp 1/32", ax0.tvalid, ax0.tdata); end
    repeat (5) @(posedge clk); #1;
    tx0 = 1'b1; @(posedge clk); #1; tx0 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin @(negedge clk); #2; if (q0d.size() >= 26) done = 1'b1; end
    checks++; if (!done) begin failures++; $display("FAIL stream_timeout beats=%0d exp=26", q0d.size()); end
    @(negedge clk); #2;
    checks++; if (ax0.tvalid !== 1'b0) begin failures++; $display("FAIL tvalid_drop got=%0b exp=0", ax0.tvalid); end
    for (int i = 0; i < 26; i++) begin
      e = exp_s[i];
      checks++; if (q0d[i] !== e || q0l[i] !== (i == 25)) begin failures++; $display("FAIL stream_byte%0d got=%0h/%0b exp=%0h/%0b", i, q0d[i], q0l[i], e, (i == 25)); end
    end
    repeat (5) @(posedge clk); #1;
    checks++; if (q0d.size() !== 26 || ax0.tvalid !== 1'b0) begin failures++; $display("FAIL tx_while_busy beats=%0d exp=26", q0d.size()); end
  endtask

  task automatic test_overflow_case();
    string exp_s;
    logic [7:0] e;
    bit done;
    exp_s = "12345678";
    q1d.delete(); q1l.delete();
    send_frame(1, "GPZDA,123456789", 8'h00, 1'b0);
    checks++; if ({g1, b1, o1} !== {16'd0, 16'd0, 16'd1}) begin failures++; $display("FAIL overflow cnts good=%0d bad=%0d ovr=%0d exp 0/0/1", g1, b1, o1); end
    checks++; if (fv1 !== 1'b0) begin failures++; $display("FAIL overflow_nocommit fv=%0b exp=0", fv1); end
    // "GPZDA," xors to 0x64 and "12345678" to 0x08, so the digits sent are "6c".
    send_frame(1, "GPZDA,12345678", 8'h00, 1'b1);
    checks++; if (g1 !== 16'd1 || fv1 !== 1'b1 || fl1 !== 4'd8) begin failures++; $display("FAIL lower_hex good=%0d fv=%0b len=%0d exp 1/1/8", g1, fv1, fl1); end
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); #2; if (q1d.size() >= 8 && !ax1.tvalid) done = 1'b1; end
    checks++; if (!done || q1d.size() !== 8) begin failures++; $display("FAIL auto_stream beats=%0d exp=8", q1d.size()); end
    for (int i = 0; i < 8; i++) begin
      e = exp_s[i];
      checks++; if (q1d[i] !== e || q1l[i] !== (i == 7)) begin failures++; $display("FAIL auto_byte%0d got=%0h/%0b exp=%0h/%0b", i, q1d[i], q1l[i], e, (i == 7)); end
    end
  endtask

  task automatic test_back_to_back();
    string exp_s;
    logic [7:0] e;
    exp_s = "ABCDEFGH";
    @(posedge clk); #1;
    q1d.delete(); q1l.delete(); stall_err = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin ax1.tready = (i % 2 == 0); @(posedge clk); #1; end
      end
      begin
        send_frame(1, "GPZDA,ABCDEFGH", 8'h00, 1'b0);
        send_frame(1, "GPZDA,x", 8'h00, 1'b0);
      end
    join
    ax1.tready = 1'b1;
    checks++; if (ax1.tvalid !== 1'b0 || q1d.size() !== 8) begin failures++; $display("FAIL bp_done tvalid=%0b beats=%0d exp 0/8", ax1.tvalid, q1d.size()); end
    for (int i = 0; i < 8; i++) begin
      e = exp_s[i];
      checks++; if (q1d[i] !== e || q1l[i] !== (i == 7)) begin failures++; $display("FAIL bp_byte%0d got=%0h/%0b exp=%0h/%0b", i, q1d[i], q1l[i], e, (i == 7)); end
    end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    checks++; if (o1 !== 16'd2 || g1 !== 16'd2) begin failures++; $display("FAIL bp_drop ovr=%0d good=%0d exp 2/2", o1, g1); end
    checks++; if (fl1 !== 4'd8) begin failures++; $display("FAIL bp_len got=%0d exp=8", fl1); end
  endtask

  task automatic test_reset_midstream();
    bit done;
    q0d.delete(); q0l.delete();
    ax0.tready = 1'b1;
    tx0 = 1'b1; @(posedge clk); #1; tx0 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); #2; if (q0d.size() >= 5) done = 1'b1; end
    checks++; if (!done) begin failures++; $display("FAIL rst_mid_timeout beats=%0d exp=5", q0d.size()); end
    rst_n = 1'b0; #1;
    checks++; if ({ax0.tvalid, ax0.tlast, ax0.tdata} !== 10'h0) begin failures++; $display("FAIL rst_mid_stream got=%0h exp=0", {ax0.tvalid, ax0.tlast, ax0.tdata}); end
    checks++; if ({g0, b0, o0, fv0, fl0} !== 55'h0) begin failures++; $display("FAIL rst_mid_dut0 got=%0h exp=0", {g0, b0, o0, fv0, fl0}); end
    checks++; if ({g1, b1, o1, fv1, fl1} !== 53'h0) begin failures++; $display("FAIL rst_mid_dut1 got=%0h exp=0", {g1, b1, o1, fv1, fl1}); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    checks++; if (q0d.size() !== 5 || ax0.tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_nobeats beats=%0d tvalid=%0b exp 5/0", q0d.size(), ax0.tvalid); end
  endtask

  initial begin
    test_reset();
    test_bad_checksum();
    test_wrong_id();
    test_stream();
    test_overflow_case();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
